// File: rtl/regfile_pkg.sv
// Shared register-file types and sizes.
// Imported by the register file and by its write-back controller.
package regfile_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned REG_AW = $clog2(NREG);

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xword_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between two requesters, the issue stage and the register-file write port.
// The master modport is the requester/issue side; the slave modport is the controller.
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN = regfile_pkg::XLEN,
  parameter int unsigned NREG = regfile_pkg::NREG
);

  logic             valid0;
  logic             valid1;
  reg_addr_t        addr0;
  reg_addr_t        addr1;
  logic [XLEN-1:0]  data0;
  logic [XLEN-1:0]  data1;
  logic             ready0;
  logic             ready1;
  logic             reserve_valid;
  reg_addr_t        reserve_addr;
  logic             we3;
  reg_addr_t        addr3;
  logic [XLEN-1:0]  writeData3;
  logic [NREG-1:0]  pending;

  modport master (
    output valid0, valid1, addr0, addr1, data0, data1, reserve_valid, reserve_addr,
    input  ready0, ready1, we3, addr3, writeData3, pending
  );

  modport slave (
    input  valid0, valid1, addr0, addr1, data0, data1, reserve_valid, reserve_addr,
    output ready0, ready1, we3, addr3, writeData3, pending
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter. The pointer names the requester with priority
// and moves to the other requester after every grant.
module rr_arbiter2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid0_i,
  input  logic valid1_i,
  output logic ready0_o,
  output logic ready1_o
);

  logic rr_q, rr_d;

  always_comb begin
    ready0_o = valid0_i & (~valid1_i | ~rr_q);
    ready1_o = valid1_i & (~valid0_i | rr_q);
    rr_d     = rr_q;
    if (ready0_o) begin
      rr_d = 1'b1;
    end else if (ready1_o) begin
      rr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back controller for the register file's single write port: round-robin between
// two requesters, registered write port, and a pending-write scoreboard for RAW stalls.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN = regfile_pkg::XLEN,
  parameter int unsigned NREG = regfile_pkg::NREG
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wb_arbiter_if.slave bus
);

  logic            ready0, ready1, xfer;
  reg_addr_t       sel_addr;
  logic [XLEN-1:0] sel_data;

  logic            we3_q, we3_d;
  reg_addr_t       addr3_q, addr3_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [NREG-1:0] pending_q, pending_d;

  rr_arbiter2 u_arb (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .valid0_i (bus.valid0),
    .valid1_i (bus.valid1),
    .ready0_o (ready0),
    .ready1_o (ready1)
  );

  always_comb begin
    xfer     = ready0 | ready1;
    sel_addr = ready1 ? bus.addr1 : bus.addr0;
    sel_data = ready1 ? bus.data1 : bus.data0;
  end

  // x0 writes are accepted but never reach the register file.
  always_comb begin
    we3_d   = xfer && (sel_addr != '0);
    addr3_d = xfer ? sel_addr : addr3_q;
    wdata_d = xfer ? sel_data : wdata_q;
  end

  // Clear on commit first so a same-edge reservation (younger) wins.
  always_comb begin
    pending_d = pending_q;
    if (we3_q) begin
      pending_d[addr3_q] = 1'b0;
    end
    if (bus.reserve_valid && (bus.reserve_addr != '0)) begin
      pending_d[bus.reserve_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3_q     <= 1'b0;
      addr3_q   <= '0;
      wdata_q   <= '0;
      pending_q <= '0;
    end else begin
      we3_q     <= we3_d;
      addr3_q   <= addr3_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
    end
  end

  assign bus.ready0     = ready0;
  assign bus.ready1     = ready1;
  assign bus.we3        = we3_q;
  assign bus.addr3      = addr3_q;
  assign bus.writeData3 = wdata_q;
  assign bus.pending    = pending_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a behavioural register file on the write port.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [31:0] rf [32] = '{default: '0};
  always @(posedge clk) if (bus.we3) rf[bus.addr3] <= bus.writeData3;

  task automatic idle_inputs();
    bus.valid0 = 1'b0; bus.valid1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.data0 = '0; bus.data1 = '0;
    bus.reserve_valid = 1'b0; bus.reserve_addr = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    bus.valid0 = 1'b1; bus.addr0 = 5'd3; bus.data0 = 32'h0000_0033;
    bus.reserve_valid = 1'b1; bus.reserve_addr = 5'd9;
    @(posedge clk); #1;
    checks++; if (bus.we3 !== 1'b1) begin errors++; $display("FAIL rst_pre_we3: got %0h want 1", bus.we3); end
    checks++; if (bus.pending !== 32'h0000_0200) begin errors++; $display("FAIL rst_pre_pending: got %h want 00000200", bus.pending); end
    bus.reserve_valid = 1'b0;
    #2 rst_n = 1'b0; #1;
    checks++; if (bus.we3 !== 1'b0) begin errors++; $display("FAIL rst_we3: got %0h want 0", bus.we3); end
    checks++; if (bus.pending !== 32'h0) begin errors++; $display("FAIL rst_pending: got %h want 0", bus.pending); end
    checks++; if (bus.addr3 !== 5'd0) begin errors++; $display("FAIL rst_addr3: got %0d want 0", bus.addr3); end
    checks++; if (bus.writeData3 !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", bus.writeData3); end
    @(posedge clk); #1;
    checks++; if (bus.we3 !== 1'b0) begin errors++; $display("FAIL rst_hold_we3: got %0h want 0", bus.we3); end
    @(negedge clk);
    rst_n = 1'b1; bus.addr0 = 5'd1; bus.data0 = 32'h0000_FFFF;
    #1;
    checks++; if (bus.ready0 !== 1'b1 || bus.ready1 !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b%0b want 10", bus.ready0, bus.ready1); end
    @(posedge clk); #1;
    checks++; if (bus.we3 !== 1'b1) begin errors++; $display("FAIL post_rst_we3: got %0h want 1", bus.we3); end
    checks++; if (bus.addr3 !== 5'd1) begin errors++; $display("FAIL post_rst_addr3: got %0d want 1", bus.addr3); end
    checks++; if (bus.writeData3 !== 32'h0000_FFFF) begin errors++; $display("FAIL post_rst_wdata: got %h want 0000ffff", bus.writeData3); end
    @(negedge clk); idle_inputs();
    @(posedge clk); #1;
    checks++; if (rf[1] !== 32'h0000_FFFF) begin errors++; $display("FAIL post_rst_rf1: got %h want 0000ffff", rf[1]); end
    checks++; if (rf[3] !== 32'h0) begin errors++; $display("FAIL rst_discard_rf3: got %h want 0", rf[3]); end
    checks++; if (bus.we3 !== 1'b0) begin errors++; $display("FAIL post_rst_we3_drop: got %0h want 0", bus.we3); end
  endtask

  task automatic test_contention();
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    do_reset();
    @(negedge clk);
    bus.valid0 = 1'b1; bus.addr0 = 5'd2;  bus.data0 = 32'h0000_2222;
    bus.valid1 = 1'b1; bus.addr1 = 5'd31; bus.data1 = 32'hFFFF_0000;
    for (int i = 0; i < 4; i++) begin
      exp_addr = (i % 2 == 0) ? 5'd2 : 5'd31;
      exp_data = (i % 2 == 0) ? 32'h0000_2222 : 32'hFFFF_0000;
      #1;
      checks++; if (bus.ready0 !== (i % 2 == 0) || bus.ready1 !== (i % 2 == 1)) begin
        errors++; $display("FAIL contend_ready[%0d]: got %0b%0b want %0b%0b", i, bus.ready0, bus.ready1, (i % 2 == 0), (i % 2 == 1));
      end
      @(posedge clk); #1;
      checks++; if (bus.we3 !== 1'b1 || bus.addr3 !== exp_addr || bus.writeData3 !== exp_data) begin
        errors++; $display("FAIL contend_out[%0d]: got we=%0b a=%0d d=%h want we=1 a=%0d d=%h", i, bus.we3, bus.addr3, bus.writeData3, exp_addr, exp_data);
      end
      @(negedge clk);
    end
    idle_inputs();
    @(posedge clk); #1;
    checks++; if (rf[31] !== 32'hFFFF_0000) begin errors++; $display("FAIL contend_rf31: got %h want ffff0000", rf[31]); end
    checks++; if (rf[2] !== 32'h0000_2222) begin errors++; $display("FAIL contend_rf2: got %h want 00002222", rf[2]); end
  endtask

  task automatic test_x0_write();
    @(negedge clk);
    bus.valid1 = 1'b1; bus.addr1 = 5'd0; bus.data1 = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus.ready1 !== 1'b1 || bus.ready0 !== 1'b0) begin errors++; $display("FAIL x0_ready: got %0b%0b want 01", bus.ready0, bus.ready1); end
    @(posedge clk); #1;
    checks++; if (bus.we3 !== 1'b0) begin errors++; $display("FAIL x0_we3: got %0h want 0", bus.we3); end
    checks++; if (bus.addr3 !== 5'd0 || bus.writeData3 !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL x0_out: got a=%0d d=%h want a=0 d=deadbeef", bus.addr3, bus.writeData3);
    end
    @(negedge clk); idle_inputs();
    @(posedge clk); #1;
    checks++; if (rf[0] !== 32'h0) begin errors++; $display("FAIL x0_rf0: got %h want 0", rf[0]); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk); bus.reserve_valid = 1'b1; bus.reserve_addr = 5'd5;
    @(posedge clk); #1;
    checks++; if (bus.pending !== 32'h0000_0020) begin errors++; $display("FAIL sb_set: got %h want 00000020", bus.pending); end
    @(negedge clk);
    bus.reserve_valid = 1'b0; bus.valid0 = 1'b1; bus.addr0 = 5'd5; bus.data0 = 32'h0000_0055;
    @(posedge clk); #1;
    checks++; if (bus.pending[5] !== 1'b1 || bus.we3 !== 1'b1) begin
      errors++; $display("FAIL sb_inflight: got p5=%0b we=%0b want p5=1 we=1", bus.pending[5], bus.we3);
    end
    @(negedge clk); idle_inputs();
    @(posedge clk); #1;
    checks++; if (bus.pending !== 32'h0) begin errors++; $display("FAIL sb_clear: got %h want 0", bus.pending); end
    checks++; if (rf[5] !== 32'h0000_0055) begin errors++; $display("FAIL sb_rf5: got %h want 00000055", rf[5]); end
  endtask

  task automatic test_collision();
    @(negedge clk);
    bus.reserve_valid = 1'b1; bus.reserve_addr = 5'd7;
    bus.valid0 = 1'b1; bus.addr0 = 5'd7; bus.data0 = 32'h0000_0077;
    @(posedge clk); #1;
    checks++; if (bus.pending !== 32'h0000_0080 || bus.we3 !== 1'b1 || bus.addr3 !== 5'd7) begin
      errors++; $display("FAIL coll_pre: got p=%h we=%0b a=%0d want p=00000080 we=1 a=7", bus.pending, bus.we3, bus.addr3);
    end
    @(negedge clk); bus.valid0 = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.pending !== 32'h0000_0080) begin errors++; $display("FAIL coll_setwins: got %h want 00000080", bus.pending); end
    @(negedge clk); bus.reserve_addr = 5'd0;
    @(posedge clk); #1;
    checks++; if (bus.pending !== 32'h0000_0080) begin errors++; $display("FAIL coll_res_x0: got %h want 00000080", bus.pending); end
    checks++; if (rf[7] !== 32'h0000_0077) begin errors++; $display("FAIL coll_rf7: got %h want 00000077", rf[7]); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.we3 !== 1'b0 || bus.addr3 !== 5'd7 || bus.writeData3 !== 32'h0000_0077) begin
        errors++; $display("FAIL idle[%0d]: got we=%0b a=%0d d=%h want we=0 a=7 d=00000077", i, bus.we3, bus.addr3, bus.writeData3);
      end
    end
    // Last grant went to requester 0, so requester 1 must win now.
    @(negedge clk);
    bus.valid0 = 1'b1; bus.addr0 = 5'd10; bus.data0 = 32'h0000_00A0;
    bus.valid1 = 1'b1; bus.addr1 = 5'd11; bus.data1 = 32'h0000_00B1;
    #1;
    checks++; if (bus.ready1 !== 1'b1 || bus.ready0 !== 1'b0) begin errors++; $display("FAIL idle_rr: got %0b%0b want 01", bus.ready0, bus.ready1); end
    @(posedge clk); #1;
    checks++; if (bus.addr3 !== 5'd11 || bus.writeData3 !== 32'h0000_00B1) begin
      errors++; $display("FAIL idle_rr_out: got a=%0d d=%h want a=11 d=000000b1", bus.addr3, bus.writeData3);
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [4:0] a;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      a = 5'd12 + 5'(i);
      bus.valid0 = 1'b1; bus.addr0 = a; bus.data0 = 32'h1000_0000 + 32'(i);
      @(posedge clk); #1;
      checks++; if (bus.we3 !== 1'b1 || bus.addr3 !== a || bus.writeData3 !== 32'h1000_0000 + 32'(i)) begin
        errors++; $display("FAIL b2b[%0d]: got we=%0b a=%0d d=%h want we=1 a=%0d d=%h", i, bus.we3, bus.addr3, bus.writeData3, a, 32'h1000_0000 + 32'(i));
      end
      @(negedge clk);
    end
    idle_inputs();
    @(posedge clk); #1;
    checks++; if (rf[12] !== 32'h1000_0000 || rf[13] !== 32'h1000_0001 || rf[14] !== 32'h1000_0002) begin
      errors++; $display("FAIL b2b_rf: got %h %h %h want 10000000 10000001 10000002", rf[12], rf[13], rf[14]);
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_contention();
    test_x0_write();
    test_scoreboard();
    test_collision();
    test_idle();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back controller for the 32×32 register file's single write port (`we3`/`addr3`/`writeData3`). It arbitrates round-robin between two write-back requesters: requester 0 is the single-cycle ALU path and requester 1 is the multi-cycle load/mul path. It drives the write port from registered outputs. It also keeps a pending-write scoreboard that issue logic uses for RAW hazard stalls.

## Interface
Parameters:
- `XLEN`, 32, data width
- `NREG`, 32, register count; address width is `$clog2(NREG)` = 5

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `valid0`, `valid1`  in  1  write-back request from requester 0 / 1
- `addr0`, `addr1`  in  5  destination register
- `data0`, `data1`  in  XLEN  write data
- `ready0`, `ready1`  out  1  grant; a transfer occurs on an edge where `valid_i && ready_i`
- `reserve_valid`  in  1  issue stage reserves a destination
- `reserve_addr`  in  5  register being reserved
- `we3`  out  1  register-file write enable (registered)
- `addr3`  out  5  register-file write address (registered)
- `writeData3`  out  XLEN  register-file write data (registered)
- `pending`  out  NREG  bit r = 1 while a write to register r is outstanding

## Operation
- **Arbitration** is combinational from `valid0`, `valid1` and the 1-bit pointer `rr`; `rr` names the requester that has priority.
  - Only one valid: it gets ready.
  - Both valid: requester `rr` gets ready; the other sees ready=0.
  - Neither valid: both ready=0.
- **Pointer update:** after a transfer, `rr` moves to the non-granted requester. With no transfer, `rr` holds.
- **No backpressure downstream:** every cycle can accept exactly one transfer.
- **Output register, transfer edge:** `we3 <= (addr != 0)`, `addr3 <= addr`, `writeData3 <= data`.
- **Output register, no-transfer edge:** `we3 <= 0`; `addr3` and `writeData3` hold.
- **Writes to x0** are handshaken (ready=1) and then dropped: `we3` stays 0.
- **Scoreboard set:** `reserve_valid && reserve_addr != 0` sets `pending[reserve_addr]` at the edge.
- **Scoreboard clear:** `we3 == 1` clears `pending[addr3]` at the same edge the register file commits the write.
- **Set and clear of the same register on one edge:** set wins, because the new reservation is younger.
- `pending[0]` is constantly 0.
- No check is made that a write matches a reservation. Unreserved writes simply commit.

## Timing
- **Reset values:** `we3` = 0, `addr3` = 0, `writeData3` = 0, `pending` = 0, `rr` = 0 (requester 0 first).
- **Reset mid-operation:** in-flight output-register contents are discarded and no write occurs.
- **Latency:**
  - Transfer at edge N: `we3` is high during cycle N+1.
  - Register file writes at edge N+1.
  - `readData` reflects the new value after N+1, and `pending` is clear after N+1.
- **Throughput:** one write per cycle, sustained.
- **Fairness:** with both requesters continuously valid, grants alternate 0,1,0,1…
- **Ready semantics:** `ready_i` may depend combinationally on `valid_j`. Requesters must not make `valid` depend on `ready`.

## Structure
- **Shared package `regfile_pkg`:** `XLEN`, `NREG`, `REG_AW`, typedefs `reg_addr_t` (logic[4:0]) and `xword_t` (logic[31:0]). The register file and this block both import it.
- **Sub-module `rr_arbiter2`:** two-input round-robin grant plus pointer flop, async active-low reset.
- Output register and scoreboard stay in the top module.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-stream with `valid0` = 1 → `we3` = 0 and `pending` = 0 immediately. After release, `valid0` = 1, `addr0` = 1, `data0` = 0000FFFF → `we3` = 1, `addr3` = 1, `writeData3` = 0000FFFF one cycle later. Connected regfile then reads 0000FFFF on addr 1.
- **Contention:** `valid0` and `valid1` both held 4 cycles (addr0 = 2, addr1 = 31, data1 = FFFF0000) → ready pattern 0,1,0,1 from reset. `addr3` sequence is 2,31,2,31; regfile x31 = FFFF0000.
- **x0 write:** `valid1` = 1, `addr1` = 0, `data1` = DEADBEEF → `ready1` = 1, `we3` stays 0, regfile x0 reads 00000000.
- **Scoreboard:**
  - `reserve_valid` with addr 5 → `pending[5]` = 1 next cycle.
  - Write to addr 5 accepted at edge N → `pending[5]` still 1 in cycle N+1, 0 after edge N+1.
- **Set/clear collision:** reserve addr 7 on the same edge `we3` commits addr 7 → `pending[7]` remains 1. Reserve addr 0 → `pending` unchanged.
- **Idle:** no valid for 3 cycles → `we3` = 0 throughout, `rr` unchanged, `addr3`/`writeData3` hold their last values.
